// File: rtl/mem_arbiter_if.sv
// Request/acknowledge and memory-side signals of the fetch/data arbiter.
// The slave side belongs to the arbiter; the master side belongs to the requesters and the memory.
interface mem_arbiter_if #(
  parameter int AddrWidth = 8,
  parameter int DataWidth = 16
);
  logic                 A_Req;
  logic [AddrWidth-1:0] A_Addr;
  logic                 A_Ack;
  logic [DataWidth-1:0] A_RData;

  logic                 B_Req;
  logic                 B_We;
  logic [AddrWidth-1:0] B_Addr;
  logic [DataWidth-1:0] B_WData;
  logic                 B_Ack;
  logic [DataWidth-1:0] B_RData;

  logic [AddrWidth-1:0] Mem_Address;
  logic [DataWidth-1:0] Mem_DIn;
  logic                 Mem_Write_EN;
  logic                 Mem_En;
  logic [DataWidth-1:0] Mem_DOut;

  logic                 Busy;

  modport slave (
    input  A_Req, A_Addr, B_Req, B_We, B_Addr, B_WData, Mem_DOut,
    output A_Ack, A_RData, B_Ack, B_RData,
    output Mem_Address, Mem_DIn, Mem_Write_EN, Mem_En, Busy
  );

  modport master (
    output A_Req, A_Addr, B_Req, B_We, B_Addr, B_WData, Mem_DOut,
    input  A_Ack, A_RData, B_Ack, B_RData,
    input  Mem_Address, Mem_DIn, Mem_Write_EN, Mem_En, Busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch (A) / data (B) arbiter in front of a negedge single-port BRAM; MEM_ARB_ROUND_ROBIN_EN makes ties round-robin (else B wins).
// Latency: request sampled to Ack in 2 posedges; at most one access every 3 cycles.
// Backpressure: a losing Req simply stays pending; requesters drop Req in their Ack cycle.
module mem_arbiter #(
  parameter int AddrWidth = 8,
  parameter int DataWidth = 16
) (
  input logic          Clk,
  input logic          Reset_N,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t               state_q, state_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] din_q, din_d;
  logic [DataWidth-1:0] a_rdata_q, a_rdata_d;
  logic [DataWidth-1:0] b_rdata_q, b_rdata_d;
  logic                 a_ack_q, a_ack_d;
  logic                 b_ack_q, b_ack_d;
  logic                 busy_q, busy_d;
  logic                 sel_b_q, sel_b_d;
  logic                 wr_q, wr_d;
  logic                 grant_b;
  logic                 b_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_b_q, last_b_d;
  // On a tie the port that did not win last time gets the memory.
  assign grant_b = bus.B_Req & (~bus.A_Req | ~last_b_q);
`else
  assign grant_b = bus.B_Req;
`endif

  assign b_write = grant_b & bus.B_We;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q   <= IDLE;
      mem_en_q  <= 1'b1;
      mem_we_q  <= 1'b1;
      addr_q    <= '0;
      din_q     <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
      sel_b_q   <= 1'b0;
      wr_q      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_b_q  <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      mem_en_q  <= mem_en_d;
      mem_we_q  <= mem_we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      busy_q    <= busy_d;
      sel_b_q   <= sel_b_d;
      wr_q      <= wr_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_b_q  <= last_b_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_en_d  = mem_en_q;
    mem_we_d  = mem_we_q;
    addr_d    = addr_q;
    din_d     = din_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    sel_b_d   = sel_b_q;
    wr_d      = wr_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_b_d  = last_b_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.A_Req | bus.B_Req) begin
          sel_b_d  = grant_b;
          wr_d     = b_write;
          addr_d   = grant_b ? bus.B_Addr : bus.A_Addr;
          if (b_write) din_d = bus.B_WData;
          mem_en_d = 1'b0;
          mem_we_d = ~b_write;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_b_d = grant_b;
`endif
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        // The memory has registered DOut on the negedge inside this cycle.
        mem_en_d = 1'b1;
        mem_we_d = 1'b1;
        if (!wr_q) begin
          if (sel_b_q) b_rdata_d = bus.Mem_DOut;
          else         a_rdata_d = bus.Mem_DOut;
        end
        a_ack_d = ~sel_b_q;
        b_ack_d = sel_b_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.Mem_En       = mem_en_q;
  assign bus.Mem_Write_EN = mem_we_q;
  assign bus.Mem_Address  = addr_q;
  assign bus.Mem_DIn      = din_q;
  assign bus.A_Ack        = a_ack_q;
  assign bus.B_Ack        = b_ack_q;
  assign bus.A_RData      = a_rdata_q;
  assign bus.B_RData      = b_rdata_q;
  assign bus.Busy         = busy_q;
endmodule
